fetch_redirect_ctrl: RTL and testbench

Front-end fetch sequencer that owns the PC register and drives the instruction-fetch request. It consumes the pre-decode flags and immediate of the instruction currently in fetch. It redirects the PC early for JAL, and for backward B-type branches when the BTFN predictor is enabled. It stalls fetch on JALR until execute resolves it, and applies execute-stage redirects with highest priority.

---
 rtl/fetch_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: front-end fetch sequencer.
// Owns the PC, issues fetch requests and redirects early on JAL, optionally on
// backward B-type branches, stalls on JALR, and gives execute redirects top
// priority. Optional feature macro: FETCH_BTFN_PREDICT_EN (backward-taken /
// forward-not-taken prediction for B-type branches).
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             inst_valid_i,
  input  logic             inst_jal_i,
  input  logic             inst_jalr_i,
  input  logic             inst_bxx_i,
  input  logic [31:0]      imm_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_addr_i,
  output logic [31:0]      pc_o,
  output logic             pc_req_o,
  output logic [31:0]      inst_addr_o,
  output logic             pred_taken_o,
  output logic             kill_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, JALR_WAIT} state_t;

`ifdef FETCH_BTFN_PREDICT_EN
  localparam bit BTFN_EN = 1'b1;
`else
  localparam bit BTFN_EN = 1'b0;
`endif

  state_t           state, state_next;
  logic [31:0]      pc, pc_next;
  logic [31:0]      inst_addr, inst_addr_next;
  logic             kill, kill_next;
  logic [CNT_W-1:0] cnt;
  logic             bxx_taken;
  logic             pred_taken;

  // Backward branches (negative immediate) are taken only with BTFN enabled.
  assign bxx_taken  = BTFN_EN & inst_bxx_i & imm_i[31];
  assign pred_taken = inst_valid_i & (inst_jal_i | bxx_taken);

  // State, PC, fetched-word address and kill flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      inst_addr <= RESET_PC;
      kill      <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      inst_addr <= inst_addr_next;
      kill      <= kill_next;
    end
  end

  // Next-state / next-PC selection; redirect beats hold beats decode.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    inst_addr_next = inst_addr;
    kill_next      = 1'b0;
    case (state)
      BOOT: begin
        // First request goes out at RESET_PC on the following cycle.
        state_next = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          pc_next        = redirect_addr_i;
          inst_addr_next = pc;
          kill_next      = 1'b1;
        end else if (hold_i) begin
          // Everything frozen; the current request is not accepted.
        end else begin
          // The request at pc is accepted this cycle.
          inst_addr_next = pc;
          if (inst_valid_i && inst_jalr_i) begin
            // The word already requested at pc is wrong-path; stop fetching.
            state_next = JALR_WAIT;
            kill_next  = 1'b1;
          end else if (pred_taken) begin
            pc_next   = inst_addr + imm_i;
            kill_next = 1'b1;
          end else begin
            pc_next = pc + 32'd4;
          end
        end
      end
      JALR_WAIT: begin
        // No fetch in flight here, so nothing needs killing on exit.
        if (redirect_i) begin
          state_next = RUN;
          pc_next    = redirect_addr_i;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // Saturating count of execute-stage redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (redirect_i && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pc_o           = pc;
  assign pc_req_o       = (state == RUN);
  assign inst_addr_o    = inst_addr;
  assign pred_taken_o   = pred_taken;
  assign kill_o         = kill;
  assign redirect_cnt_o = cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: table-driven vectors with a scoreboard
// queue, plus hand sequences for counter saturation and async reset.
module tb_fetch_redirect_ctrl;

`ifdef FETCH_BTFN_PREDICT_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  localparam logic [31:0] RPC = 32'h80;
  localparam int          CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold_i, inst_valid_i, inst_jal_i, inst_jalr_i, inst_bxx_i;
  logic [31:0]   imm_i;
  logic          redirect_i;
  logic [31:0]   redirect_addr_i;
  logic [31:0]   pc_o;
  logic          pc_req_o;
  logic [31:0]   inst_addr_o;
  logic          pred_taken_o;
  logic          kill_o;
  logic [CW-1:0] redirect_cnt_o;

  fetch_redirect_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .inst_valid_i(inst_valid_i),
    .inst_jal_i(inst_jal_i), .inst_jalr_i(inst_jalr_i), .inst_bxx_i(inst_bxx_i),
    .imm_i(imm_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .pc_o(pc_o), .pc_req_o(pc_req_o), .inst_addr_o(inst_addr_o),
    .pred_taken_o(pred_taken_o), .kill_o(kill_o), .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold, valid, jal, jalr, bxx;
    logic [31:0] imm;
    logic        redir;
    logic [31:0] raddr;
    logic        e_pred;
    logic [31:0] e_pc;
    logic        e_req, e_kill;
    logic [31:0] e_iaddr;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  function automatic vec_t mk(logic h, logic v, logic j, logic jr, logic b,
                              logic [31:0] imm, logic r, logic [31:0] ra,
                              logic ep, logic [31:0] epc, logic ereq,
                              logic ekill, logic [31:0] eia, int ecnt);
    vec_t t;
    t.hold = h; t.valid = v; t.jal = j; t.jalr = jr; t.bxx = b; t.imm = imm;
    t.redir = r; t.raddr = ra; t.e_pred = ep; t.e_pc = epc; t.e_req = ereq;
    t.e_kill = ekill; t.e_iaddr = eia; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; drives one vector, checks across the edge.
  task automatic apply(vec_t v);
    vec_t e;
    hold_i = v.hold; inst_valid_i = v.valid; inst_jal_i = v.jal;
    inst_jalr_i = v.jalr; inst_bxx_i = v.bxx; imm_i = v.imm;
    redirect_i = v.redir; redirect_addr_i = v.raddr;
    sb.push_back(v);
    #1;
    chk($sformatf("t%0d pred", txn), {31'b0, pred_taken_o}, {31'b0, v.e_pred});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("t%0d pc", txn), pc_o, e.e_pc);
    chk($sformatf("t%0d req", txn), {31'b0, pc_req_o}, {31'b0, e.e_req});
    chk($sformatf("t%0d kill", txn), {31'b0, kill_o}, {31'b0, e.e_kill});
    chk($sformatf("t%0d iaddr", txn), inst_addr_o, e.e_iaddr);
    chk($sformatf("t%0d cnt", txn), {28'b0, redirect_cnt_o}, e.e_cnt[31:0]);
    $display("txn %0d: pc=%08h req=%0b kill=%0b iaddr=%08h pred=%0b cnt=%0d",
             txn, pc_o, pc_req_o, kill_o, inst_addr_o, v.e_pred, redirect_cnt_o);
    txn++;
    @(negedge clk);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " pc"}, pc_o, RPC);
    chk({tag, " req"}, {31'b0, pc_req_o}, 32'd0);
    chk({tag, " iaddr"}, inst_addr_o, RPC);
    chk({tag, " kill"}, {31'b0, kill_o}, 32'd0);
    chk({tag, " pred"}, {31'b0, pred_taken_o}, 32'd0);
    chk({tag, " cnt"}, {28'b0, redirect_cnt_o}, 32'd0);
  endtask

  initial begin
    // Idle / redirect shorthands keep the table readable.
    //              h v j jr b imm          r ra             ep     pc                 req k      iaddr              cnt
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h80,            1,0,     32'h80,            0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h84,            1,0,     32'h80,            0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h88,            1,0,     32'h84,            0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'h100,       0,     32'h100,           1,1,     32'h88,            1));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h104,           1,0,     32'h100,           1));
    // JAL at 0x100, imm 0x40
    vecs.push_back(mk(0,1,1,0,0,32'h40,      0,32'h0,         1,     32'h140,           1,1,     32'h104,           1));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h144,           1,0,     32'h140,           1));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'h200,       0,     32'h200,           1,1,     32'h144,           2));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h204,           1,0,     32'h200,           2));
    // backward bxx at 0x200, imm -8
    vecs.push_back(mk(0,1,0,0,1,32'hFFFF_FFF8,0,32'h0,        BTFN,  BTFN ? 32'h1F8 : 32'h208, 1,BTFN, 32'h204,    2));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     BTFN ? 32'h1FC : 32'h20C, 1,0, BTFN ? 32'h1F8 : 32'h208, 2));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'h200,       0,     32'h200,           1,1,     BTFN ? 32'h1FC : 32'h20C, 3));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h204,           1,0,     32'h200,           3));
    // forward bxx at 0x200, imm +16: never taken
    vecs.push_back(mk(0,1,0,0,1,32'h10,      0,32'h0,         0,     32'h208,           1,0,     32'h204,           3));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'h300,       0,     32'h300,           1,1,     32'h208,           4));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h304,           1,0,     32'h300,           4));
    // JALR at 0x300, then wait (hold ignored), then redirect to 0x500
    vecs.push_back(mk(0,1,0,1,0,32'h0,       0,32'h0,         0,     32'h304,           0,1,     32'h304,           4));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h304,           0,0,     32'h304,           4));
    vecs.push_back(mk(1,0,0,0,0,32'h0,       0,32'h0,         0,     32'h304,           0,0,     32'h304,           4));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h304,           0,0,     32'h304,           4));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'h500,       0,     32'h500,           1,0,     32'h304,           5));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h504,           1,0,     32'h500,           5));
    // hold freezes, then redirect + hold + JAL: redirect wins
    vecs.push_back(mk(1,0,0,0,0,32'h0,       0,32'h0,         0,     32'h504,           1,0,     32'h500,           5));
    vecs.push_back(mk(1,1,1,0,0,32'h40,      1,32'h600,       1,     32'h600,           1,1,     32'h504,           6));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h604,           1,0,     32'h600,           6));
    // PC wrap
    vecs.push_back(mk(0,0,0,0,0,32'h0,       1,32'hFFFF_FFFC, 0,     32'hFFFF_FFFC,     1,1,     32'h604,           7));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h0,             1,0,     32'hFFFF_FFFC,     7));
    // JALR decode together with redirect: stays in RUN
    vecs.push_back(mk(0,1,0,1,0,32'h0,       1,32'h700,       0,     32'h700,           1,1,     32'h0,             8));
    vecs.push_back(mk(0,0,0,0,0,32'h0,       0,32'h0,         0,     32'h704,           1,0,     32'h700,           8));

    hold_i = 0; inst_valid_i = 0; inst_jal_i = 0; inst_jalr_i = 0; inst_bxx_i = 0;
    imm_i = 0; redirect_i = 0; redirect_addr_i = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    #1;
    chk_reset("boot");

    foreach (vecs[i]) apply(vecs[i]);

    // Counter saturation: keep redirecting to 0x800 past 4'hF.
    for (int i = 0; i < 9; i++) begin
      apply(mk(0,0,0,0,0,32'h0, 1,32'h800, 0, 32'h800, 1,1,
               (i == 0) ? 32'h704 : 32'h800, (9 + i > 15) ? 15 : 9 + i));
    end
    apply(mk(0,0,0,0,0,32'h0, 0,32'h0, 0, 32'h804, 1,0, 32'h800, 15));
    // Enter JALR_WAIT, then assert reset asynchronously.
    apply(mk(0,1,0,1,0,32'h0, 0,32'h0, 0, 32'h804, 0,1, 32'h804, 15));
    apply(mk(0,0,0,0,0,32'h0, 0,32'h0, 0, 32'h804, 0,0, 32'h804, 15));
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("reboot");
    apply(mk(0,0,0,0,0,32'h0, 0,32'h0, 0, 32'h80, 1,0, 32'h80, 0));
    apply(mk(0,0,0,0,0,32'h0, 0,32'h0, 0, 32'h84, 1,0, 32'h80, 0));
    apply(mk(0,0,0,0,0,32'h0, 0,32'h0, 0, 32'h88, 1,0, 32'h84, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
